// File: rtl/bcd_time_core.sv
// rtl/bcd_time_core.sv - single-clock BCD time-of-day core with set-mode FSM
//
// Purpose:
//   Keeps hh:mm:ss as six BCD digits, advanced once per TICK_DIV cycles of
//   MCLK through an internal one-cycle tick enable (no derived clocks).
//   A small FSM lets the user step through the hour, minute and second
//   fields and adjust each one with plus/minus pulses.
//
// Parameters:
//   TICK_DIV   MCLK cycles per second tick (>= 2)
//   HOUR_24    1: hours 00..23; 0: hours 12,01..11 with pm flag
//   BLINK_DIV  MCLK cycles per blink half-period in set mode (>= 1)
//
// Ports:
//   MCLK, RESET_N          clock, asynchronous active-low reset
//   mode_p                 pulse: RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN
//   plus_p, minus_p        pulses: step selected field up/down (set states)
//   clear_p                pulse: synchronous clear to midnight, back to RUN
//   sec_u/sec_t, min_u/min_t, hr_u/hr_t   BCD digits
//   pm                     12h mode PM flag (always 0 in 24h mode)
//   edit_sel               one-hot {hr,min,sec} field under edit, 000 in RUN
//   blink                  blink phase of edited field, 0 in RUN
//   tick                   one-cycle pulse when the running time advanced
//   day_wrap               one-cycle pulse on midnight rollover

module bcd_time_core #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int HOUR_24   = 1,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic       MCLK,
    input  logic       RESET_N,
    input  logic       mode_p,
    input  logic       plus_p,
    input  logic       minus_p,
    input  logic       clear_p,
    output logic [3:0] sec_u,
    output logic [3:0] sec_t,
    output logic [3:0] min_u,
    output logic [3:0] min_t,
    output logic [3:0] hr_u,
    output logic [3:0] hr_t,
    output logic       pm,
    output logic [2:0] edit_sel,
    output logic       blink,
    output logic       tick,
    output logic       day_wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(BLINK_DIV + 1);

    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);

    // Hours reset to 00 in 24h mode and to 12 (midnight, am) in 12h mode.
    localparam logic [7:0] HR_RST = (HOUR_24 != 0) ? 8'h00 : 8'h12;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SET_HR,
        ST_SET_MIN,
        ST_SET_SEC
    } state_t;

    state_t        state;
    logic [PW-1:0] prescale;
    logic [BW-1:0] blink_cnt;

    // Each field is held as {tens, units} BCD.
    logic [7:0] sec_r;
    logic [7:0] min_r;
    logic [7:0] hr_r;

    // ---------------------------------------------------------------
    // BCD step helpers
    // ---------------------------------------------------------------

    // 00..59 increment with wrap.
    function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) begin
                return 8'h00;
            end
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // 00..59 decrement with wrap.
    function automatic logic [7:0] bcd60_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) begin
            if (v[7:4] == 4'd0) begin
                return 8'h59;
            end
            return {v[7:4] - 4'd1, 4'd9};
        end
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Hour increment; bit 8 of the result requests a pm toggle, which
    // happens only on the 11 -> 12 step in 12h mode.
    function automatic logic [8:0] hr_inc(input logic [7:0] h);
        if (HOUR_24 != 0) begin
            if (h == 8'h23) begin
                return {1'b0, 8'h00};
            end
        end else begin
            if (h == 8'h12) begin
                return {1'b0, 8'h01};
            end
            if (h == 8'h11) begin
                return {1'b1, 8'h12};
            end
        end
        if (h[3:0] == 4'd9) begin
            return {1'b0, h[7:4] + 4'd1, 4'd0};
        end
        return {1'b0, h[7:4], h[3:0] + 4'd1};
    endfunction

    // Hour decrement; mirror of hr_inc, toggling pm on 12 -> 11.
    function automatic logic [8:0] hr_dec(input logic [7:0] h);
        if (HOUR_24 != 0) begin
            if (h == 8'h00) begin
                return {1'b0, 8'h23};
            end
        end else begin
            if (h == 8'h01) begin
                return {1'b0, 8'h12};
            end
            if (h == 8'h12) begin
                return {1'b1, 8'h11};
            end
        end
        if (h[3:0] == 4'd0) begin
            return {1'b0, h[7:4] - 4'd1, 4'd9};
        end
        return {1'b0, h[7:4], h[3:0] - 4'd1};
    endfunction

    logic [7:0] sec_up;
    logic [7:0] sec_dn;
    logic [7:0] min_up;
    logic [7:0] min_dn;
    logic [8:0] hr_up;
    logic [8:0] hr_dn;
    logic       sec_last;
    logic       min_last;
    logic       hr_last;

    assign sec_up = bcd60_inc(sec_r);
    assign sec_dn = bcd60_dec(sec_r);
    assign min_up = bcd60_inc(min_r);
    assign min_dn = bcd60_dec(min_r);
    assign hr_up  = hr_inc(hr_r);
    assign hr_dn  = hr_dec(hr_r);

    assign sec_last = (sec_r == 8'h59);
    assign min_last = (min_r == 8'h59);
    // Last hour of the day: 23 in 24h mode, 11 pm in 12h mode.
    assign hr_last  = (HOUR_24 != 0) ? (hr_r == 8'h23) : ((hr_r == 8'h11) && pm);

    // ---------------------------------------------------------------
    // FSM, prescaler, time registers and registered flags
    // ---------------------------------------------------------------
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_RUN;
            prescale  <= '0;
            blink_cnt <= '0;
            sec_r     <= 8'h00;
            min_r     <= 8'h00;
            hr_r      <= HR_RST;
            pm        <= 1'b0;
            edit_sel  <= 3'b000;
            blink     <= 1'b0;
            tick      <= 1'b0;
            day_wrap  <= 1'b0;
        end else begin
            tick     <= 1'b0;
            day_wrap <= 1'b0;

            if (clear_p) begin
                state     <= ST_RUN;
                prescale  <= '0;
                blink_cnt <= '0;
                sec_r     <= 8'h00;
                min_r     <= 8'h00;
                hr_r      <= HR_RST;
                pm        <= 1'b0;
                edit_sel  <= 3'b000;
                blink     <= 1'b0;
            end else if (mode_p) begin
                // Every transition restarts both counters, so leaving
                // SET_SEC gives a full second before the first tick and
                // each set state starts its blink in the visible phase.
                prescale  <= '0;
                blink_cnt <= '0;
                case (state)
                    ST_RUN: begin
                        state    <= ST_SET_HR;
                        edit_sel <= 3'b100;
                        blink    <= 1'b1;
                    end
                    ST_SET_HR: begin
                        state    <= ST_SET_MIN;
                        edit_sel <= 3'b010;
                        blink    <= 1'b1;
                    end
                    ST_SET_MIN: begin
                        state    <= ST_SET_SEC;
                        edit_sel <= 3'b001;
                        blink    <= 1'b1;
                    end
                    default: begin
                        state    <= ST_RUN;
                        edit_sel <= 3'b000;
                        blink    <= 1'b0;
                    end
                endcase
            end else if (state == ST_RUN) begin
                if (prescale == PRE_MAX) begin
                    prescale <= '0;
                    tick     <= 1'b1;
                    sec_r    <= sec_up;
                    if (sec_last) begin
                        min_r <= min_up;
                        if (min_last) begin
                            hr_r <= hr_up[7:0];
                            if (hr_up[8]) begin
                                pm <= ~pm;
                            end
                            day_wrap <= hr_last;
                        end
                    end
                end else begin
                    prescale <= prescale + 1'b1;
                end
            end else begin
                prescale <= '0;

                if (blink_cnt == BLK_MAX) begin
                    blink_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end

                // Simultaneous plus and minus cancel out.
                if (plus_p ^ minus_p) begin
                    case (state)
                        ST_SET_HR: begin
                            hr_r <= plus_p ? hr_up[7:0] : hr_dn[7:0];
                            if (plus_p ? hr_up[8] : hr_dn[8]) begin
                                pm <= ~pm;
                            end
                        end
                        ST_SET_MIN: min_r <= plus_p ? min_up : min_dn;
                        default:    sec_r <= plus_p ? sec_up : sec_dn;
                    endcase
                end
            end
        end
    end

    assign sec_u = sec_r[3:0];
    assign sec_t = sec_r[7:4];
    assign min_u = min_r[3:0];
    assign min_t = min_r[7:4];
    assign hr_u  = hr_r[3:0];
    assign hr_t  = hr_r[7:4];

endmodule

// File: tb/tb_bcd_time_core.sv
// tb/tb_bcd_time_core.sv - directed self-checking bench for bcd_time_core

module tb_bcd_time_core;

    logic MCLK = 1'b0;
    logic RESET_N = 1'b0;
    logic mode_p = 1'b0;
    logic plus_p = 1'b0;
    logic minus_p = 1'b0;
    logic clear_p = 1'b0;

    logic [3:0] a_sec_u, a_sec_t, a_min_u, a_min_t, a_hr_u, a_hr_t;
    logic       a_pm, a_blink, a_tick, a_day_wrap;
    logic [2:0] a_edit_sel;

    logic [3:0] b_sec_u, b_sec_t, b_min_u, b_min_t, b_hr_u, b_hr_t;
    logic       b_pm, b_blink, b_tick, b_day_wrap;
    logic [2:0] b_edit_sel;

    int total = 0;
    int bad = 0;

    always #5 MCLK = ~MCLK;

    bcd_time_core #(.TICK_DIV(4), .HOUR_24(1), .BLINK_DIV(2)) dut_24 (
        .MCLK(MCLK), .RESET_N(RESET_N), .mode_p(mode_p), .plus_p(plus_p),
        .minus_p(minus_p), .clear_p(clear_p),
        .sec_u(a_sec_u), .sec_t(a_sec_t), .min_u(a_min_u), .min_t(a_min_t),
        .hr_u(a_hr_u), .hr_t(a_hr_t), .pm(a_pm), .edit_sel(a_edit_sel),
        .blink(a_blink), .tick(a_tick), .day_wrap(a_day_wrap)
    );

    bcd_time_core #(.TICK_DIV(4), .HOUR_24(0), .BLINK_DIV(2)) dut_12 (
        .MCLK(MCLK), .RESET_N(RESET_N), .mode_p(mode_p), .plus_p(plus_p),
        .minus_p(minus_p), .clear_p(clear_p),
        .sec_u(b_sec_u), .sec_t(b_sec_t), .min_u(b_min_u), .min_t(b_min_t),
        .hr_u(b_hr_u), .hr_t(b_hr_t), .pm(b_pm), .edit_sel(b_edit_sel),
        .blink(b_blink), .tick(b_tick), .day_wrap(b_day_wrap)
    );

    logic [23:0] t24;
    logic [23:0] t12;
    assign t24 = {a_hr_t, a_hr_u, a_min_t, a_min_u, a_sec_t, a_sec_u};
    assign t12 = {b_hr_t, b_hr_u, b_min_t, b_min_u, b_sec_t, b_sec_u};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge MCLK);
        #1;
    endtask

    task automatic pulse(input bit m, input bit p, input bit n, input bit c);
        mode_p = m;
        plus_p = p;
        minus_p = n;
        clear_p = c;
        cyc();
        mode_p = 1'b0;
        plus_p = 1'b0;
        minus_p = 1'b0;
        clear_p = 1'b0;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        cyc();
        RESET_N = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        int tick_err;
        int wraps;
        int blink_err;
        int frozen_err;

        // ---------------- 1: reset state and 60 seconds in 24h ----------
        do_reset();
        chk("rst_time24", t24, 24'h000000);
        chk("rst_time12", t12, 24'h120000);
        chk("rst_pm12", b_pm, 1'b0);
        chk("rst_flags", {a_tick, a_day_wrap, a_blink, a_edit_sel}, 6'b0);

        ticks = 0;
        tick_err = 0;
        wraps = 0;
        for (int i = 1; i <= 240; i++) begin
            cyc();
            if (a_tick) ticks++;
            if (a_tick !== ((i % 4) == 0)) tick_err++;
            if (a_day_wrap) wraps++;
        end
        chk("t1_time", t24, 24'h000100);
        chk("t1_ticks", ticks, 60);
        chk("t1_tick_period_err", tick_err, 0);
        chk("t1_day_wrap", wraps, 0);

        // ---------------- 2: set 23:59:59 and roll over midnight --------
        pulse(1, 0, 0, 0);
        chk("t2_sel_hr", a_edit_sel, 3'b100);
        pulse(0, 0, 1, 0);                       // 00 -> 23
        pulse(1, 0, 0, 0);
        chk("t2_sel_min", a_edit_sel, 3'b010);
        pulse(0, 0, 1, 0);                       // 01 -> 00
        pulse(0, 0, 1, 0);                       // 00 -> 59
        pulse(1, 0, 0, 0);
        chk("t2_sel_sec", a_edit_sel, 3'b001);
        pulse(0, 0, 1, 0);                       // 00 -> 59
        pulse(1, 0, 0, 0);
        chk("t2_set_time", t24, 24'h235959);
        chk("t2_run_sel_blink", {a_edit_sel, a_blink}, 4'b0000);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("t2_pre_tick", {a_tick, a_day_wrap}, 2'b00);
        end
        cyc();
        chk("t2_wrap_time", t24, 24'h000000);
        chk("t2_wrap_flags", {a_tick, a_day_wrap}, 2'b11);
        cyc();
        chk("t2_wrap_gone", a_day_wrap, 1'b0);

        // ---------------- 3: 12h hour stepping and pm -------------------
        do_reset();
        chk("t3_rst12", {t12, 3'b000, b_pm}, {24'h120000, 4'h0});
        pulse(1, 0, 0, 0);
        for (int i = 0; i < 11; i++) pulse(0, 1, 0, 0);
        chk("t3_hr11", {b_hr_t, b_hr_u, 3'b000, b_pm}, 12'h110);
        pulse(0, 1, 0, 0);
        chk("t3_hr12pm", {b_hr_t, b_hr_u, 3'b000, b_pm}, 12'h121);
        pulse(0, 0, 1, 0);
        chk("t3_hr11am", {b_hr_t, b_hr_u, 3'b000, b_pm}, 12'h110);
        for (int i = 0; i < 12; i++) pulse(0, 1, 0, 0);
        chk("t3_hr11pm", {b_hr_t, b_hr_u, 3'b000, b_pm}, 12'h111);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);                       // min 00 -> 59
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);                       // sec 00 -> 59
        pulse(1, 0, 0, 0);
        chk("t3_set12", t12, 24'h115959);
        repeat (4) cyc();
        chk("t3_wrap12_time", {t12, 3'b000, b_pm}, {24'h120000, 4'h0});
        chk("t3_wrap12_flags", {b_tick, b_day_wrap}, 2'b11);

        // ---------------- 4: minute wrap and same-cycle priorities ------
        do_reset();
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        chk("t4_min59", t24, 24'h005900);
        pulse(0, 1, 1, 0);
        chk("t4_plus_minus", t24, 24'h005900);
        pulse(1, 1, 0, 0);
        chk("t4_mode_plus_sel", a_edit_sel, 3'b001);
        chk("t4_mode_plus_time", t24, 24'h005900);

        // ---------------- 5: hold in SET_HR -----------------------------
        do_reset();
        pulse(1, 0, 0, 0);
        chk("t5_entry_blink", a_blink, 1'b1);
        blink_err = 0;
        frozen_err = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (a_blink !== (((i >> 1) & 1) == 0)) blink_err++;
            if (t24 !== 24'h000000 || a_tick !== 1'b0 || a_edit_sel !== 3'b100) frozen_err++;
        end
        chk("t5_blink_err", blink_err, 0);
        chk("t5_frozen_err", frozen_err, 0);
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        chk("t5_run_exit", {a_edit_sel, a_blink}, 4'b0000);

        // ---------------- 6: clear mid-edit, then async reset -----------
        do_reset();
        pulse(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        for (int i = 0; i < 27; i++) pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        cyc();
        chk("t6_preset", {t24, 5'b0, a_edit_sel}, {24'h073312, 8'h02});
        pulse(0, 0, 0, 1);
        chk("t6_clear_time", t24, 24'h000000);
        chk("t6_clear_flags", {a_edit_sel, a_blink, a_tick, a_day_wrap}, 6'b0);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("t6_no_tick", a_tick, 1'b0);
        end
        cyc();
        chk("t6_first_tick", {t24, 7'b0, a_tick}, {24'h000001, 8'h01});
        cyc();
        #2;
        RESET_N = 1'b0;
        #1;
        chk("t6_async_rst", {t24, 4'b0, a_tick, a_edit_sel}, 32'h0);
        RESET_N = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
